// File: rtl/addsub_seq_8bit.sv
// addsub_seq_8bit: sequencing front end for the 8-bit ripple add/sub datapath.
// Accepts one request at a time over in_valid/in_ready, conditions operand B for
// subtraction, waits SETTLE_CYC cycles for the ripple chain, captures the adder
// outputs and presents them over out_valid/out_ready. Keeps an accumulator
// (ops 10/11) and a sticky overflow flag.
// Optional build macro: ADDSUB_SAT_EN -- saturate captured results on overflow.
module addsub_seq_8bit #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] adder_a,
    output logic [7:0] adder_b,
    output logic       adder_cin,
    input  logic [7:0] adder_s,
    input  logic       adder_cout,
    input  logic       adder_ov,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_s,
    output logic       out_cout,
    output logic       out_ov,
    output logic [7:0] acc,
    output logic       ov_sticky,
    input  logic       clr_sticky
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg;
    logic [7:0] opa_reg, opb_reg;
    logic       cin_reg;
    logic       acc_op_reg;
    logic [7:0] out_s_reg;
    logic       out_cout_reg, out_ov_reg;
    logic [7:0] acc_reg;
    logic       ov_sticky_reg;

    logic       accept, capture;
    logic [7:0] cap_s;

    // Result value to capture: raw sum, or clamped toward the A operand's sign on overflow.
`ifdef ADDSUB_SAT_EN
    assign cap_s = adder_ov ? (opa_reg[7] ? 8'h80 : 8'h7F) : adder_s;
`else
    assign cap_s = adder_s;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake strobes.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg == 4'd0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Settle counter: loaded on acceptance, counts down while the ripple chain settles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= 4'd0;
        end else if (accept) begin
            cnt_reg <= CNT_LOAD;
        end else if (state_reg == SETTLE && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Operand register: drives the adder directly and holds until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_reg    <= 8'h00;
            opb_reg    <= 8'h00;
            cin_reg    <= 1'b0;
            acc_op_reg <= 1'b0;
        end else if (accept) begin
            opa_reg    <= in_op[1] ? acc_reg : in_a;
            opb_reg    <= in_op[0] ? ~in_b : in_b;
            cin_reg    <= in_op[0];
            acc_op_reg <= in_op[1];
        end
    end

    // Result registers: loaded once per operation at the end of the settle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_s_reg    <= 8'h00;
            out_cout_reg <= 1'b0;
            out_ov_reg   <= 1'b0;
        end else if (capture) begin
            out_s_reg    <= cap_s;
            out_cout_reg <= adder_cout;
            out_ov_reg   <= adder_ov;
        end
    end

    // Accumulator: updated only by the accumulator ops, with the captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= 8'h00;
        end else if (capture && acc_op_reg) begin
            acc_reg <= cap_s;
        end
    end

    // Sticky overflow: a capture with overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_sticky_reg <= 1'b0;
        end else if (capture && adder_ov) begin
            ov_sticky_reg <= 1'b1;
        end else if (clr_sticky) begin
            ov_sticky_reg <= 1'b0;
        end
    end

    assign adder_a   = opa_reg;
    assign adder_b   = opb_reg;
    assign adder_cin = cin_reg;
    assign out_s     = out_s_reg;
    assign out_cout  = out_cout_reg;
    assign out_ov    = out_ov_reg;
    assign acc       = acc_reg;
    assign ov_sticky = ov_sticky_reg;

endmodule

// File: tb/tb_addsub_seq_8bit.sv
// Testbench for addsub_seq_8bit: directed vector table, hand-written corner
// sequences (backpressure, sticky clear, reset mid-operation) and randomized
// operations checked against an arithmetic reference model.
module tb_addsub_seq_8bit;

    localparam int SETTLE = 2;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_a, in_b;
    logic [7:0] adder_a, adder_b;
    logic       adder_cin;
    logic [7:0] adder_s;
    logic       adder_cout, adder_ov;
    logic       out_valid, out_ready;
    logic [7:0] out_s;
    logic       out_cout, out_ov;
    logic [7:0] acc;
    logic       ov_sticky, clr_sticky;

    always #5 clk = ~clk;

    addsub_seq_8bit #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_s(adder_s), .adder_cout(adder_cout), .adder_ov(adder_ov),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_cout(out_cout), .out_ov(out_ov),
        .acc(acc), .ov_sticky(ov_sticky), .clr_sticky(clr_sticky)
    );

    // Stand-in for the external ripple adder.
    logic [8:0] adder_full;
    always_comb begin
        adder_full = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};
        adder_s    = adder_full[7:0];
        adder_cout = adder_full[8];
        adder_ov   = (adder_a[7] == adder_b[7]) && (adder_full[7] != adder_a[7]);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model state.
    logic [7:0] m_acc;
    logic       m_sticky;

    // Operation semantics in plain integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] s, output logic c, output logic v);
        logic [7:0]        ua;
        logic signed [7:0] ta, tb;
        int                r, sr;
        ua = op[1] ? m_acc : a;
        ta = ua;
        tb = b;
        if (op[0]) begin
            r  = int'(ua) - int'(b);
            c  = (int'(ua) >= int'(b));
            sr = int'(ta) - int'(tb);
        end else begin
            r  = int'(ua) + int'(b);
            c  = (r > 255);
            sr = int'(ta) + int'(tb);
        end
        v = (sr > 127) || (sr < -128);
        s = 8'(r);
        if (SAT && v) s = ua[7] ? 8'h80 : 8'h7F;
    endfunction

    // One complete transaction; returns observed and model results.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input bit clr_cap,
                          output logic [7:0] s, output logic c, output logic v,
                          output logic [7:0] es, output logic ec, output logic ev);
        logic [7:0] expa, expb;
        int k;
        model(op, a, b, es, ec, ev);
        expa = op[1] ? m_acc : a;
        expb = op[0] ? ~b : b;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        check("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("adder_a", adder_a, expa);
        check("adder_b", adder_b, expb);
        check("adder_cin", adder_cin, op[0]);
        check("in_ready_busy", in_ready, 0);
        k = 0;
        clr_sticky = clr_cap && (SETTLE - 1 == 0);
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
            clr_sticky = clr_cap && (k == SETTLE - 1);
        end
        clr_sticky = 1'b0;
        check("latency", k, SETTLE);
        s = out_s; c = out_cout; v = out_ov;
        if (op[1]) m_acc = es;
        m_sticky = ev | (m_sticky & ~clr_cap);
        check("acc", acc, m_acc);
        check("ov_sticky", ov_sticky, m_sticky);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_s", out_s, s);
            check("hold_in_ready", in_ready, 0);
            in_valid = 1'b1; in_op = ~op; in_a = ~a; in_b = ~b;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("consumed", {out_valid, in_ready}, 2'b01);
        $display("op=%0d a=%02h b=%02h -> s=%02h c=%0d v=%0d acc=%02h sticky=%0d",
                 op, a, b, s, c, v, acc, ov_sticky);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b, s;
        logic       c, v;
        logic [7:0] acc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [7:0] s, es;
        logic c, v, ec, ev;
        logic [1:0] rop;
        logic [7:0] ra, rb;

        tbl[0] = '{2'd0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{2'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{2'd2, 8'h00, 8'h10, 8'h10, 1'b0, 1'b0, 8'h10};
        tbl[3] = '{2'd0, 8'h7F, 8'h01, (SAT ? 8'h7F : 8'h80), 1'b0, 1'b1, 8'h10};
        tbl[4] = '{2'd2, 8'hAA, 8'h20, 8'h30, 1'b0, 1'b0, 8'h30};
        tbl[5] = '{2'd1, 8'h80, 8'h01, (SAT ? 8'h80 : 8'h7F), 1'b1, 1'b1, 8'h30};
        tbl[6] = '{2'd3, 8'h55, 8'h05, 8'h2B, 1'b1, 1'b0, 8'h2B};
        tbl[7] = '{2'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h2B};
        tbl[8] = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8'h2B};

        rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = 8'h00; in_b = 8'h00;
        out_ready = 1'b1; clr_sticky = 1'b0;
        m_acc = 8'h00; m_sticky = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", {out_s, out_cout, out_ov}, 0);
        check("rst_acc_sticky", {acc, ov_sticky}, 0);
        check("rst_adder", {adder_a, adder_b, adder_cin}, 0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, 1'b0, s, c, v, es, ec, ev);
            check($sformatf("vec%0d_s", i), s, tbl[i].s);
            check($sformatf("vec%0d_cout", i), c, tbl[i].c);
            check($sformatf("vec%0d_ov", i), v, tbl[i].v);
            check($sformatf("vec%0d_acc", i), acc, tbl[i].acc);
        end
        check("sticky_after_vectors", ov_sticky, 1);

        // Backpressure: result held for 5 cycles while a new request is offered.
        run_op(2'd0, 8'h12, 8'h34, 5, 1'b0, s, c, v, es, ec, ev);
        check("bp_s", s, 8'h46);
        repeat (SETTLE + 2) @(negedge clk);
        check("bp_ignored_req", out_valid, 0);
        check("bp_acc", acc, 8'h2B);

        // Sticky clear pulse.
        @(negedge clk); clr_sticky = 1'b1;
        @(negedge clk); clr_sticky = 1'b0;
        m_sticky = 1'b0;
        check("clr_sticky", ov_sticky, 0);

        // Clear on the same edge as an overflowing capture: the set wins.
        run_op(2'd0, 8'h7F, 8'h01, 0, 1'b1, s, c, v, es, ec, ev);
        check("clr_vs_set", ov_sticky, 1);
        // Clear on the same edge as a clean capture: the clear takes effect.
        run_op(2'd0, 8'h05, 8'h03, 0, 1'b1, s, c, v, es, ec, ev);
        check("clr_at_clean_capture", ov_sticky, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            run_op(rop, ra, rb, $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                   s, c, v, es, ec, ev);
            check($sformatf("rnd%0d_s", i), s, es);
            check($sformatf("rnd%0d_cout", i), c, ec);
            check($sformatf("rnd%0d_ov", i), v, ev);
        end

        // Reset during SETTLE: operation abandoned, outputs return to reset values at once.
        run_op(2'd2, 8'h00, 8'h5A, 0, 1'b0, s, c, v, es, ec, ev);
        @(negedge clk);
        in_op = 2'd2; in_b = 8'h44; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_acc", acc, 8'h00);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_adder", {adder_a, adder_b, adder_cin}, 0);
        check("midrst_out", {out_s, out_cout, out_ov, ov_sticky}, 0);
        @(negedge clk);
        rst = 1'b0;
        m_acc = 8'h00; m_sticky = 1'b0;
        run_op(2'd2, 8'h00, 8'h44, 0, 1'b0, s, c, v, es, ec, ev);
        check("post_rst_s", s, 8'h44);
        check("post_rst_acc", acc, 8'h44);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_seq_8bit.md
# addsub_seq_8bit

Sequencing front end for the team's 8-bit ripple add/sub datapath (`add_8bit`): accepts operation requests over a valid/ready handshake and conditions operand B for subtraction. It drives the adder's A/B/carry-in ports, waits a programmable settle time for the ripple chain, and registers sum/carry/overflow. It also keeps an 8-bit accumulator and a sticky overflow flag, and presents results downstream over a second valid/ready handshake.

## Interface
- `SETTLE_CYC`, default 2: cycles (1..15) between driving the adder and capturing its outputs.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_op`  in  2  00 A+B, 01 A−B, 10 ACC+B, 11 ACC−B.
- `in_a`  in  8  operand A (ignored for ops 10/11).
- `in_b`  in  8  operand B.
- `adder_a`  out  8  to adder A.
- `adder_b`  out  8  to adder B (B, or ~B when subtracting).
- `adder_cin`  out  1  to adder `addsub` carry-in (1 when subtracting).
- `adder_s`  in  8  adder sum.
- `adder_cout`  in  1  adder carry-out.
- `adder_ov`  in  1  adder signed-overflow flag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_s`  out  8  registered result.
- `out_cout`  out  1  registered carry (for subtraction, 1 = no borrow).
- `out_ov`  out  1  registered signed overflow of this op.
- `acc`  out  8  accumulator value.
- `ov_sticky`  out  1  OR of all `out_ov` since last clear.
- `clr_sticky`  in  1  synchronous clear of `ov_sticky`.

## Operation
- States: IDLE, SETTLE, HOLD.
- IDLE: `in_ready`=1. On `in_valid`, latch operands in an operand register, load the counter with `SETTLE_CYC`−1, and go to SETTLE.
  - A operand: `in_a` for ops 00/01, current `acc` for ops 10/11.
  - Subtraction (`in_op[0]`=1): B operand = ~`in_b` and cin = 1. Otherwise B = `in_b` and cin = 0.
- `adder_a`/`adder_b`/`adder_cin` come straight from the operand register. They are stable from the cycle after acceptance until the next acceptance. They are 0 after reset.
- SETTLE: the counter decrements each cycle. When it reads 0, capture `adder_s`/`adder_cout`/`adder_ov` into the `out_*` registers, set `out_valid`, and go to HOLD.
  - On the same edge, for ops 10/11, write the captured (possibly saturated) result into `acc`.
  - On the same edge, OR `adder_ov` into `ov_sticky`.
- HOLD: `out_valid`=1 and the `out_*` registers hold. When `out_valid`&&`out_ready`, clear `out_valid` and return to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap: one operation in flight.
- `clr_sticky` clears `ov_sticky` on the next edge. If a capture with ov=1 happens on that same edge, the set wins and `ov_sticky`=1.
- Accumulator arithmetic is modulo 256 when saturation is compiled out.

## Timing
- Request accepted at edge t. Adder inputs are valid after t. Capture happens at edge t+`SETTLE_CYC`; `out_valid` is high from t+`SETTLE_CYC`.
- Minimum request-to-request spacing: `SETTLE_CYC`+1 cycles (one HOLD cycle with `out_ready`=1, then IDLE).
- `out_ready` held low: HOLD persists indefinitely and outputs do not change.
- Values after reset:
  - State IDLE, `in_ready`=1.
  - `out_valid`=0, `out_s`=0x00, `out_cout`=0, `out_ov`=0.
  - `acc`=0x00, `ov_sticky`=0, all `adder_*`=0.
- Reset asserted mid-SETTLE or mid-HOLD: the operation is abandoned and every output returns to its reset value immediately. `acc` is not updated.

## Configuration
- `ADDSUB_SAT_EN` defined: when `adder_ov`=1 at capture, the captured `out_s` (and any `acc` write) is saturated.
  - Saturated value is 0x7F if the A operand's bit 7 is 0, else 0x80.
  - `out_ov` still reports 1 and `out_cout` is the raw adder value.
- `ADDSUB_SAT_EN` undefined: `out_s` is the raw `adder_s` (wrap-around).

## Test plan
- Add: op 00, A=0x05, B=0x03, `SETTLE_CYC`=2.
  - `adder_b`=0x03, `adder_cin`=0.
  - `out_valid` rises 2 cycles after acceptance with `out_s`=0x08, cout=0, ov=0.
- Subtract with borrow: op 01, A=0x03, B=0x05.
  - `adder_b`=0xFA, cin=1.
  - `out_s`=0xFE, cout=0, ov=0.
- Overflow: op 00, 0x7F+0x01 → ov=1, `ov_sticky`=1. Result is 0x80, or 0x7F with `ADDSUB_SAT_EN`.
  - Then op 01, 0x80−0x01 → ov=1. Result is 0x7F, or 0x80 with `ADDSUB_SAT_EN`.
- Accumulate: from reset, op 10 B=0x10, op 10 B=0x20, op 11 B=0x05 → `acc` = 0x10, 0x30, 0x2B. Ops 00/01 in between leave `acc` unchanged.
- Backpressure and sticky clear:
  - Hold `out_ready`=0 for 5 cycles in HOLD → `out_*` stable, `in_ready`=0, a new `in_valid` is ignored.
  - Pulse `clr_sticky` → `ov_sticky`=0 next cycle.
  - `clr_sticky` on the same edge as an ov=1 capture → `ov_sticky`=1.
- Reset mid-SETTLE: assert `rst` one cycle after accepting op 10 B=0x44 → `out_valid`=0 and `acc`=0x00 immediately. After release, a new op completes normally.
